arm_mc_controller: RTL

Multicycle control unit for the next-generation ARM core. One datapath (single ALU, shared instruction/data memory port) runs each instruction over several cycles. The block replaces the single-cycle controller and adds:
- a memory ready handshake with wait states;
- a registered NZCV flags register;
- conditional execution;
- a parametrised bus timeout that drives a sticky fault state.

---
 rtl/arm_mc_pkg.sv | 75 +++++++
 rtl/arm_cond_check.sv | 36 +++
 rtl/arm_mc_controller.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multicycle ARM controller: state codes, datapath
// select values, instruction field constants and condition codes.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_FAULT    = 4'd15
    } state_t;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_ORR   = 3'b011;
    localparam logic [2:0] ALU_EOR   = 3'b100;
    localparam logic [2:0] ALU_PASSB = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

    function automatic logic cmd_supported(input logic [3:0] cmd);
        return cmd inside {CMD_AND, CMD_EOR, CMD_SUB, CMD_ADD, CMD_CMP, CMD_ORR, CMD_MOV};
    endfunction

    // Logical ops and MOV leave carry and overflow untouched.
    function automatic logic cmd_is_logical(input logic [3:0] cmd);
        return cmd inside {CMD_AND, CMD_EOR, CMD_ORR, CMD_MOV};
    endfunction

    function automatic logic [2:0] alu_of_cmd(input logic [3:0] cmd);
        logic [2:0] alu;
        case (cmd)
            CMD_ADD:          alu = ALU_ADD;
            CMD_SUB, CMD_CMP: alu = ALU_SUB;
            CMD_AND:          alu = ALU_AND;
            CMD_ORR:          alu = ALU_ORR;
            CMD_EOR:          alu = ALU_EOR;
            CMD_MOV:          alu = ALU_PASSB;
            default:          alu = ALU_ADD;
        endcase
        return alu;
    endfunction

endpackage

// File: rtl/arm_cond_check.sv
// Evaluates an ARM condition field against the registered NZCV flags.
module arm_cond_check
    import arm_mc_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags_i;

    // NV never executes here; the controller traps it before using this result.
    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_i)
            COND_EQ: cond_ex_o = z;
            COND_NE: cond_ex_o = !z;
            COND_CS: cond_ex_o = c;
            COND_CC: cond_ex_o = !c;
            COND_MI: cond_ex_o = n;
            COND_PL: cond_ex_o = !n;
            COND_VS: cond_ex_o = v;
            COND_VC: cond_ex_o = !v;
            COND_HI: cond_ex_o = c && !z;
            COND_LS: cond_ex_o = !c || z;
            COND_GE: cond_ex_o = (n == v);
            COND_LT: cond_ex_o = (n != v);
            COND_GT: cond_ex_o = !z && (n == v);
            COND_LE: cond_ex_o = z || (n != v);
            COND_AL: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control FSM with memory wait states, registered NZCV flags,
// conditional execution and a bus timeout that traps into a sticky fault state.
module arm_mc_controller
    import arm_mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TIMEOUT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic        MemExtend,
    output logic [3:0]  Flags,
    output logic        Fault,
    output logic [3:0]  State
);

    localparam logic [TIMEOUT_W-1:0] WAIT_LAST  = TIMEOUT_W'(MEM_TIMEOUT - 1);
    localparam bit                   TIMEOUT_EN = (MEM_TIMEOUT != 0);

    state_t               state_q, state_d;
    logic [3:0]           flags_q, flags_d;
    logic [TIMEOUT_W-1:0] wait_q, wait_d;

    logic [3:0] cond;
    logic [1:0] op;
    logic [3:0] cmd;
    logic       immBit, upBit, byteBit, sBit;
    logic       condEx, memState, timedOut;
    logic       unusedInstr;

    // Instr carries bits [31:12] of the instruction, so field indices are offset by 12.
    assign cond        = Instr[19:16];
    assign op          = Instr[15:14];
    assign immBit      = Instr[13];
    assign cmd         = Instr[12:9];
    assign upBit       = Instr[11];
    assign byteBit     = Instr[10];
    assign sBit        = Instr[8];
    assign unusedInstr = ^Instr[7:0];

    arm_cond_check u_cond (
        .cond_i    (cond),
        .flags_i   (flags_q),
        .cond_ex_o (condEx)
    );

    assign memState = state_q inside {S_FETCH, S_MEMREAD, S_MEMWRITE};
    assign timedOut = TIMEOUT_EN && memState && !MemReady && (wait_q == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            flags_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ALUControl = ALU_ADD;
        RegWrite   = 1'b0;
        MemExtend  = 1'b0;
        Fault      = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                if (MemReady) begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALU;
                    state_d   = S_DECODE;
                end else if (timedOut) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (cond == COND_NV) begin
                    state_d = S_FAULT;
                end else if (!condEx) begin
                    state_d = S_FETCH;
                end else begin
                    case (op)
                        OP_DP:   state_d = !cmd_supported(cmd) ? S_FAULT :
                                           (immBit ? S_EXECI : S_EXECR);
                        OP_MEM:  state_d = S_MEMADR;
                        OP_BR:   state_d = S_BRANCH;
                        default: state_d = S_FAULT;
                    endcase
                end
            end
            S_MEMADR: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = upBit ? ALU_ADD : ALU_SUB;
                state_d    = sBit ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                MemRead = 1'b1;
                if (MemReady)      state_d = S_MEMWB;
                else if (timedOut) state_d = S_FAULT;
            end
            S_MEMWB: begin
                ResultSrc = RES_RDATA;
                RegWrite  = 1'b1;
                MemExtend = byteBit;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (MemReady)      state_d = S_FETCH;
                else if (timedOut) state_d = S_FAULT;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB    = (state_q == S_EXECI) ? SRCB_IMM : SRCB_REG;
                ALUControl = alu_of_cmd(cmd);
                if (sBit || cmd == CMD_CMP) begin
                    flags_d[3:2] = ALUFlags[3:2];
                    if (!cmd_is_logical(cmd)) flags_d[1:0] = ALUFlags[1:0];
                end
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = (cmd != CMD_CMP);
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
                PCWrite   = 1'b1;
                state_d   = S_FETCH;
            end
            S_FAULT: Fault = 1'b1;
            default: state_d = S_FAULT;
        endcase
    end

    // The wait counter restarts on every state change, so each memory state gets its own budget.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q)
            wait_d = '0;
        else if (memState && !MemReady)
            wait_d = wait_q + TIMEOUT_W'(1);
    end

    assign ImmSrc = op;
    assign RegSrc = {(op == OP_MEM) && !sBit, op == OP_BR};
    assign Flags  = flags_q;
    assign State  = state_q;

endmodule
